// File: rtl/haz_pkg.sv
// Shared types for the pipeline hazard/stall controller: forwarding selects and
// the states of the data-memory wait FSM.
package haz_pkg;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      ERR  = 2'b10
   } mem_wait_e;

endpackage

// File: rtl/haz_mem_wait_fsm.sv
// Data-memory wait FSM: freezes the pipe while M waits for its ack and raises a
// sticky timeout once an access has waited MEM_TIMEOUT cycles in WAIT.
module haz_mem_wait_fsm
   import haz_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic mem_req,
   input  logic mem_ack,
   output logic mem_stall,
   output logic mem_timeout
);

   localparam int CW = $clog2(MEM_TIMEOUT + 1);

   mem_wait_e       state;
   logic [CW-1:0]   cnt;

   // NOTE: all state uses non-blocking assignments so the order of statements
   // inside the block never changes what the flops capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         mem_timeout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (mem_req && !mem_ack) begin
                  state <= WAIT;
                  cnt   <= CW'(1);
               end
            end
            WAIT: begin
               if (mem_ack) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt == CW'(MEM_TIMEOUT)) begin
                  state       <= ERR;
                  mem_timeout <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ERR:     mem_timeout <= 1'b1;
            default: state <= IDLE;
         endcase
      end
   end

   // The ack releases the freeze in the very cycle it arrives.
   always_comb begin
      mem_stall = (state == ERR)
               || ((state == IDLE) && mem_req && !mem_ack)
               || ((state == WAIT) && !mem_ack);
   end

   // Withdrawing a request while waiting, without an ack, is a protocol error.
   req_held_in_wait : assert property (
      @(posedge clk) disable iff (reset) (state == WAIT) |-> (mem_req || mem_ack)
   );

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipe: forwarding, load-use and
// branch stalls, memory-wait freeze. Define HAZ_PERF_CNT_EN to add StallCount.
module hazard_stall_ctrl
   import haz_pkg::*;
#(
   parameter int REG_W       = 5,
   parameter int MEM_TIMEOUT = 15
`ifdef HAZ_PERF_CNT_EN
   ,
   parameter int CNT_W       = 32
`endif
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] RsD,
   input  logic [REG_W-1:0] RtD,
   input  logic [REG_W-1:0] RsE,
   input  logic [REG_W-1:0] RtE,
   input  logic [REG_W-1:0] WriteRegE,
   input  logic [REG_W-1:0] WriteRegM,
   input  logic [REG_W-1:0] WriteRegW,
   input  logic             RegWriteE,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             MemtoRegE,
   input  logic             MemtoRegM,
   input  logic             BranchD,
   input  logic             MemReqM,
   input  logic             MemAckM,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             ForwardAD,
   output logic             ForwardBD,
   output logic             MemTimeout
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] StallCount
`endif
);

   function automatic fwd_sel_e fwd_e(input logic [REG_W-1:0] rs,
                                      input logic [REG_W-1:0] wr_m,
                                      input logic [REG_W-1:0] wr_w,
                                      input logic             we_m,
                                      input logic             we_w);
      if (rs == '0)              return FWD_RF;
      if (we_m && (wr_m == rs))  return FWD_MEM;
      if (we_w && (wr_w == rs))  return FWD_WB;
      return FWD_RF;
   endfunction

   function automatic logic reads_in_d(input logic [REG_W-1:0] rd,
                                       input logic [REG_W-1:0] rs,
                                       input logic [REG_W-1:0] rt);
      return (rd != '0) && ((rd == rs) || (rd == rt));
   endfunction

   logic mem_stall;
   logic lu_hazard;
   logic br_hazard;

   haz_mem_wait_fsm #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_mem_wait (
      .clk         (clk),
      .reset       (reset),
      .mem_req     (MemReqM),
      .mem_ack     (MemAckM),
      .mem_stall   (mem_stall),
      .mem_timeout (MemTimeout)
   );

   assign ForwardAE = fwd_e(RsE, WriteRegM, WriteRegW, RegWriteM, RegWriteW);
   assign ForwardBE = fwd_e(RtE, WriteRegM, WriteRegW, RegWriteM, RegWriteW);
   assign ForwardAD = (RsD != '0) && RegWriteM && (WriteRegM == RsD);
   assign ForwardBD = (RtD != '0) && RegWriteM && (WriteRegM == RtD);

   assign lu_hazard = MemtoRegE && RegWriteE && reads_in_d(WriteRegE, RsD, RtD);
   assign br_hazard = BranchD
                   && ((RegWriteE && reads_in_d(WriteRegE, RsD, RtD))
                    || (MemtoRegM && reads_in_d(WriteRegM, RsD, RtD)));

   // A memory freeze outranks bubbles: E must keep its instruction, so the
   // load-use/branch bubble is held back until the ack lets the pipe move.
   // NOTE: every output gets a default first so no path can infer a latch.
   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b0;
      if (!reset) begin
         if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
         end else if (lu_hazard || br_hazard) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
         end
      end
   end

`ifdef HAZ_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         StallCount <= '0;
      end else if (StallF && (StallCount != '1)) begin
         StallCount <= StallCount + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios followed by
// randomized traffic compared against a cycle-level reference model.
module tb_hazard_stall_ctrl;

   localparam int REG_W = 5;
   localparam int TO    = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic [REG_W-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
   logic             RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
   logic             BranchD, MemReqM, MemAckM;
   logic             StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
   logic [1:0]       ForwardAE, ForwardBE;
   logic             ForwardAD, ForwardBD, MemTimeout;
`ifdef HAZ_PERF_CNT_EN
   logic [31:0]      StallCount;
`endif

   int passed = 0;
   int total  = 0;

   // Reference model: length of the current unacked access, sticky error flag.
   int          pending = 0;
   bit          err     = 1'b0;
   bit          exp_sf  = 1'b0;
   longint      stall_total = 0;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(
      .REG_W       (REG_W),
      .MEM_TIMEOUT (TO)
   ) dut (
`ifdef HAZ_PERF_CNT_EN
      .StallCount (StallCount),
`endif
      .clk        (clk),
      .reset      (reset),
      .RsD        (RsD),
      .RtD        (RtD),
      .RsE        (RsE),
      .RtE        (RtE),
      .WriteRegE  (WriteRegE),
      .WriteRegM  (WriteRegM),
      .WriteRegW  (WriteRegW),
      .RegWriteE  (RegWriteE),
      .RegWriteM  (RegWriteM),
      .RegWriteW  (RegWriteW),
      .MemtoRegE  (MemtoRegE),
      .MemtoRegM  (MemtoRegM),
      .BranchD    (BranchD),
      .MemReqM    (MemReqM),
      .MemAckM    (MemAckM),
      .StallF     (StallF),
      .StallD     (StallD),
      .StallE     (StallE),
      .StallM     (StallM),
      .FlushD     (FlushD),
      .FlushE     (FlushE),
      .FlushW     (FlushW),
      .ForwardAE  (ForwardAE),
      .ForwardBE  (ForwardBE),
      .ForwardAD  (ForwardAD),
      .ForwardBD  (ForwardBD),
      .MemTimeout (MemTimeout)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else passed++;
   endtask

   function automatic logic [1:0] exp_fwd(input logic [REG_W-1:0] rs);
      if (rs == 0) return 2'b00;
      if (RegWriteM && WriteRegM == rs) return 2'b10;
      if (RegWriteW && WriteRegW == rs) return 2'b01;
      return 2'b00;
   endfunction

   function automatic bit used_in_d(input logic [REG_W-1:0] r);
      return (r != 0) && (r == RsD || r == RtD);
   endfunction

   task automatic model_check();
      bit active, frozen, lu, br;
      logic [6:0] exp_sfv;
      active = (pending > 0) || MemReqM;
      frozen = err || (active && !MemAckM);
      lu = MemtoRegE && RegWriteE && used_in_d(WriteRegE);
      br = BranchD && ((RegWriteE && used_in_d(WriteRegE)) || (MemtoRegM && used_in_d(WriteRegM)));
      // order: StallF StallD StallE StallM FlushD FlushE FlushW
      if (reset)       exp_sfv = 7'b0000000;
      else if (frozen) exp_sfv = 7'b1111001;
      else if (lu || br) exp_sfv = 7'b1100010;
      else             exp_sfv = 7'b0000000;
      exp_sf = exp_sfv[6];
      check("stall_flush", {25'd0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW},
            {25'd0, exp_sfv});
      check("fwd_ae", {30'd0, ForwardAE}, {30'd0, exp_fwd(RsE)});
      check("fwd_be", {30'd0, ForwardBE}, {30'd0, exp_fwd(RtE)});
      check("fwd_ad_bd", {30'd0, ForwardAD, ForwardBD},
            {30'd0, (RsD != 0 && RegWriteM && WriteRegM == RsD), (RtD != 0 && RegWriteM && WriteRegM == RtD)});
      check("mem_timeout", {31'd0, MemTimeout}, {31'd0, err});
`ifdef HAZ_PERF_CNT_EN
      check("stall_count", StallCount, stall_total[31:0]);
`endif
   endtask

   task automatic model_update();
      if (reset) begin
         pending     = 0;
         err         = 1'b0;
         stall_total = 0;
      end else begin
         if (exp_sf && stall_total < 64'hFFFF_FFFF) stall_total++;
         if (!err && ((pending > 0) || MemReqM)) begin
            if (MemAckM) pending = 0;
            else begin
               pending++;
               if (pending == TO + 1) err = 1'b1;
            end
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      model_check();
      @(posedge clk);
      #1;
      model_update();
   endtask

   task automatic clear_inputs();
      RsD = 0; RtD = 0; RsE = 0; RtE = 0;
      WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
      RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
      MemtoRegE = 0; MemtoRegM = 0; BranchD = 0;
      MemReqM = 0; MemAckM = 0;
   endtask

   initial begin
      int err_cycles;
      reset = 1'b1;
      clear_inputs();
      cycle();
      cycle();
      check("reset_stallf", {31'd0, StallF}, 32'd0);
      check("reset_timeout", {31'd0, MemTimeout}, 32'd0);
      reset = 1'b0;

      // Scenario 1: M beats W on the same register.
      RsE = 5; WriteRegM = 5; RegWriteM = 1; WriteRegW = 5; RegWriteW = 1;
      #1 check("t1_fwd_mem", {30'd0, ForwardAE}, 32'd2);
      cycle();

      // Scenario 2: register 0 is never forwarded.
      clear_inputs();
      RsE = 0; WriteRegM = 0; RegWriteM = 1; WriteRegW = 0; RegWriteW = 1;
      #1 check("t2_fwd_r0", {30'd0, ForwardAE}, 32'd0);
      cycle();

      // Scenario 3: load-use bubble lasts exactly one cycle.
      clear_inputs();
      MemtoRegE = 1; RegWriteE = 1; WriteRegE = 7; RsD = 7;
      #1 check("t3_lu", {29'd0, StallF, StallD, FlushE}, 32'b111);
      cycle();
      MemtoRegE = 0; RegWriteE = 0;
      #1 check("t3_lu_done", {29'd0, StallF, StallD, FlushE}, 32'b000);
      cycle();

      // Scenario 4: ack on the 4th request cycle.
      clear_inputs();
      MemReqM = 1;
      for (int i = 0; i < 3; i++) begin
         #1 check("t4_wait", {27'd0, StallF, StallD, StallE, StallM, FlushW}, 32'b11111);
         cycle();
      end
      MemAckM = 1;
      #1 check("t4_ack", {27'd0, StallF, StallD, StallE, StallM, FlushW}, 32'b00000);
      cycle();
      clear_inputs();
      cycle();

      // Scenario 6: load-use bubble deferred until the memory releases.
      MemtoRegE = 1; RegWriteE = 1; WriteRegE = 7; RsD = 7; MemReqM = 1;
      #1 check("t6_frozen", {30'd0, StallF, FlushE}, 32'b10);
      cycle();
      MemAckM = 1;
      #1 check("t6_release", {29'd0, StallE, StallF, FlushE}, 32'b011);
      cycle();
      clear_inputs();
      #1 check("t6_after", {31'd0, FlushE}, 32'd0);
      cycle();

      // Scenario 5: timeout after TO wait cycles, sticky, cleared by reset.
      MemReqM = 1;
      for (int i = 0; i < TO + 1; i++) begin
         #1 check("t5_no_timeout", {31'd0, MemTimeout}, 32'd0);
         cycle();
      end
      MemReqM = 0;
      for (int i = 0; i < 2; i++) begin
         #1 check("t5_sticky", {30'd0, MemTimeout, StallF}, 32'b11);
         cycle();
      end
      reset = 1'b1;
      #1 check("t5_in_reset", {30'd0, MemTimeout, StallF}, 32'b10);
      cycle();
      reset = 1'b0;
      #1 check("t5_cleared", {31'd0, MemTimeout}, 32'd0);
      cycle();

      // Randomized traffic; requests are held while an access is waiting.
      err_cycles = 0;
      for (int n = 0; n < 3000; n++) begin
         RsD = REG_W'($urandom_range(0, 3)); RtD = REG_W'($urandom_range(0, 3));
         RsE = REG_W'($urandom_range(0, 3)); RtE = REG_W'($urandom_range(0, 3));
         WriteRegE = REG_W'($urandom_range(0, 3));
         WriteRegM = REG_W'($urandom_range(0, 3));
         WriteRegW = REG_W'($urandom_range(0, 3));
         RegWriteE = 1'($urandom_range(0, 1)); RegWriteM = 1'($urandom_range(0, 1));
         RegWriteW = 1'($urandom_range(0, 1)); MemtoRegE = 1'($urandom_range(0, 1));
         MemtoRegM = 1'($urandom_range(0, 1)); BranchD = 1'($urandom_range(0, 1));
         MemAckM = 1'($urandom_range(0, 1));
         MemReqM = (pending > 0 && !err) ? 1'b1 : ($urandom_range(0, 3) == 0);
         err_cycles = err ? err_cycles + 1 : 0;
         reset = (err_cycles >= 3) || ($urandom_range(0, 99) == 0);
         cycle();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
